dm_stage_unit: RTL and testbench
================================

Name: dm_stage_unit

Overview:
Data-memory stage of the 5-stage pipeline. It sits at the downstream end of the EX/DM pipeline register and consumes its outputs: memory read/write controls, address, store data, destination register and writeback controls. It performs word accesses on an internal data memory with configurable latency, and stalls the upstream pipeline while an access is in flight. Results are registered onto the DM/WB interface.

Parameters:
ADDR_W, 8, word-index width; memory depth is 2**ADDR_W 32-bit words.
LATENCY, 2, memory access latency in cycles; legal values are >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
mem_read_in  input  1  load request from EX/DM.
mem_write_in  input  1  store request from EX/DM.
mem_addr_in  input  32  byte address, which is the ALU result.
write_data_in  input  32  store data.
rd_in  input  5  destination register.
mem_to_reg_in  input  1  writeback select.
reg_write_in  input  1  writeback enable.
stall_out  output  1  combinational; while high, the upstream pipeline holds EX/DM contents stable.
read_data_out  output  32  load data to DM/WB.
alu_result_out  output  32  passthrough of the address/ALU result to DM/WB.
rd_out  output  5  to DM/WB.
mem_to_reg_out  output  1  to DM/WB.
reg_write_out  output  1  to DM/WB.
misalign_out  output  1  one-cycle flag: a memory op with mem_addr_in[1:0] != 0 was dropped.

Behaviour:
- Reset (asynchronous assert):
  - State goes to IDLE, the latency counter to 0, and every registered output to 0.
  - stall_out is 0 while reset is asserted.
  - Memory contents are not cleared.
  - A write in flight when reset asserts is aborted and never committed.
- FSM states: IDLE and ACCESS.
- Word index = mem_addr_in[ADDR_W+1:2]. Higher address bits are ignored, so out-of-range addresses alias (wrap).
- Memory op = mem_read_in | mem_write_in. If both are asserted, the op is treated as a write and read_data_out = 0.
- IDLE, no memory op:
  - stall_out = 0.
  - At the next edge: alu_result_out <= mem_addr_in, rd_out/mem_to_reg_out/reg_write_out <= inputs, read_data_out <= 0, misalign_out <= 0.
  - Latency is 1 cycle, the same as a plain pipeline register.
- IDLE, memory op, misaligned:
  - stall_out = 0 and no memory access.
  - At the next edge, a bubble is loaded (reg_write_out = 0, mem_to_reg_out = 0, rd_out = 0, read_data_out = 0), alu_result_out <= mem_addr_in, and misalign_out <= 1 for exactly one cycle.
- IDLE, memory op, aligned:
  - stall_out = 1 in the same cycle.
  - At the edge, capture address, data, rd and controls into holding registers, set counter = LATENCY-1, and go to ACCESS.
  - Load a bubble onto the DM/WB outputs.
- ACCESS, counter > 0:
  - stall_out = 1; the counter decrements each edge.
  - The DM/WB outputs carry a bubble (reg_write_out = 0).
  - EX/DM inputs are ignored.
- ACCESS, counter == 0:
  - stall_out = 0, so upstream advances at this edge.
  - At the edge:
    - A write commits write_data to mem[index].
    - A read loads read_data_out <= mem[index].
    - The captured rd, mem_to_reg and reg_write go to the outputs, and alu_result_out <= captured address.
    - State returns to IDLE.
- Timing of an aligned op: stall_out is high for exactly LATENCY cycles, and the result appears on the outputs LATENCY+1 edges after the op was first presented.
- A store's reg_write_in is passed through unchanged; the writeback stage ignores it for stores.
- Back-to-back memory ops: the next op is sampled in the IDLE cycle after completion, so there is no overlap.
- A load immediately following a store to the same word returns the new data.
- misalign_out is never set for non-memory ops.

Test Plan:
1. Reset mid-access: store 0xDEADBEEF to address 0x10 with LATENCY=2, assert reset during the second stall cycle, then load 0x10 → previously written value (0x00000000 if preloaded by the bench); all outputs 0 during reset.
2. Store then load: store 0x12345678 to 0x40 → stall high 2 cycles, bubble outputs. Then load 0x40 with rd=5, mem_to_reg=1, reg_write=1 → after 3 edges read_data_out = 0x12345678, rd_out = 5, alu_result_out = 0x40.
3. ALU passthrough: mem_read = mem_write = 0, addr = 0xABCD0000, rd = 7, reg_write = 1 → next edge alu_result_out = 0xABCD0000, rd_out = 7, stall_out never high.
4. Misaligned load at 0x42 → stall_out = 0; misalign_out = 1 for one cycle; reg_write_out = 0; a subsequent load of 0x40 is unaffected.
5. Address wrap, ADDR_W=8: store 0xCAFEF00D to 0x400 → a load of 0x000 returns 0xCAFEF00D.
6. Read+write both asserted with LATENCY=1 → treated as a write, read_data_out = 0, stall high 1 cycle; a later load confirms the write committed.

Source files
------------

// File: rtl/dm_stage_unit.sv
// Data-memory stage: word loads/stores on an internal memory with a fixed
// access latency. Upstream is stalled while an access is in flight, and results are registered onto DM/WB.
module dm_stage_unit #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  output logic        stall_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        misalign_out
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Op captured at issue, held until completion.
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        hold_m2r_q, hold_m2r_d;
  logic        hold_rw_q, hold_rw_d;
  logic        hold_wr_q, hold_wr_d;
  logic        hold_ld_q, hold_ld_d;

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        misalign_q, misalign_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_op, aligned, mem_we, stall_c;
  logic [ADDR_W-1:0] hold_idx;

  assign mem_op   = mem_read_in | mem_write_in;
  assign aligned  = (mem_addr_in[1:0] == 2'b00);
  assign hold_idx = hold_addr_q[ADDR_W+1:2];
  assign mem_we   = (state_q == ACCESS) && (cnt_q == '0) && hold_wr_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_rd_d    = hold_rd_q;
    hold_m2r_d   = hold_m2r_q;
    hold_rw_d    = hold_rw_q;
    hold_wr_d    = hold_wr_q;
    hold_ld_d    = hold_ld_q;
    read_data_d  = '0;
    alu_result_d = '0;
    rd_d         = '0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    misalign_d   = 1'b0;
    stall_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          alu_result_d = mem_addr_in;
          rd_d         = rd_in;
          mem_to_reg_d = mem_to_reg_in;
          reg_write_d  = reg_write_in;
        end else if (!aligned) begin
          alu_result_d = mem_addr_in;
          misalign_d   = 1'b1;
        end else begin
          stall_c     = 1'b1;
          hold_addr_d = mem_addr_in;
          hold_data_d = write_data_in;
          hold_rd_d   = rd_in;
          hold_m2r_d  = mem_to_reg_in;
          hold_rw_d   = reg_write_in;
          hold_wr_d   = mem_write_in;
          // Read+write together is a write; the load path stays quiet.
          hold_ld_d   = mem_read_in & ~mem_write_in;
          cnt_d       = CNT_W'(LATENCY - 1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          read_data_d  = hold_ld_q ? mem[hold_idx] : 32'h0;
          alu_result_d = hold_addr_q;
          rd_d         = hold_rd_q;
          mem_to_reg_d = hold_m2r_q;
          reg_write_d  = hold_rw_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_out = stall_c & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_rd_q    <= '0;
      hold_m2r_q   <= 1'b0;
      hold_rw_q    <= 1'b0;
      hold_wr_q    <= 1'b0;
      hold_ld_q    <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_rd_q    <= hold_rd_d;
      hold_m2r_q   <= hold_m2r_d;
      hold_rw_q    <= hold_rw_d;
      hold_wr_q    <= hold_wr_d;
      hold_ld_q    <= hold_ld_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      misalign_q   <= misalign_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive reset and a write
  // in flight is dropped because reset forces the state back to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[hold_idx] <= hold_data_q;
  end

  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign rd_out         = rd_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign reg_write_out  = reg_write_q;
  assign misalign_out   = misalign_q;

endmodule

// File: tb/tb_dm_stage_unit.sv
// Scoreboarded bench for dm_stage_unit: LATENCY=2 and LATENCY=1 instances,
// directed ops with hand-computed results checked cycle by cycle.
module tb_dm_stage_unit;

  typedef struct packed {
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [31:0] mem_addr_in, write_data_in;
  logic [4:0]  rd_in;

  logic        s0_stall, s0_m2r, s0_rw, s0_mis;
  logic [31:0] s0_rdata, s0_alu;
  logic [4:0]  s0_rd;
  logic        s1_stall, s1_m2r, s1_rw, s1_mis;
  logic [31:0] s1_rdata, s1_alu;
  logic [4:0]  s1_rd;

  dm_stage_unit #(.ADDR_W(8), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_addr_in(mem_addr_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .stall_out(s0_stall), .read_data_out(s0_rdata), .alu_result_out(s0_alu),
    .rd_out(s0_rd), .mem_to_reg_out(s0_m2r), .reg_write_out(s0_rw),
    .misalign_out(s0_mis)
  );

  dm_stage_unit #(.ADDR_W(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_addr_in(mem_addr_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .stall_out(s1_stall), .read_data_out(s1_rdata), .alu_result_out(s1_alu),
    .rd_out(s1_rd), .mem_to_reg_out(s1_m2r), .reg_write_out(s1_rw),
    .misalign_out(s1_mis)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  int   lat      = 2;
  exp_t exp_q[$];
  exp_t cur;
  exp_t obs;
  exp_t mon_e;

  always_comb begin
    obs = '0;
    if (sel == 0) begin
      obs.stall = s0_stall; obs.rdata = s0_rdata; obs.alu = s0_alu;
      obs.rd = s0_rd; obs.m2r = s0_m2r; obs.rw = s0_rw; obs.mis = s0_mis;
    end else begin
      obs.stall = s1_stall; obs.rdata = s1_rdata; obs.alu = s1_alu;
      obs.rd = s1_rd; obs.m2r = s1_m2r; obs.rw = s1_rw; obs.mis = s1_mis;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d) at %0t: got 0x%08h expected 0x%08h", name, sel, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stall_out", 32'(obs.stall), 32'(mon_e.stall));
      check("read_data_out", obs.rdata, mon_e.rdata);
      check("alu_result_out", obs.alu, mon_e.alu);
      check("rd_out", 32'(obs.rd), 32'(mon_e.rd));
      check("mem_to_reg_out", 32'(obs.m2r), 32'(mon_e.m2r));
      check("reg_write_out", 32'(obs.rw), 32'(mon_e.rw));
      check("misalign_out", 32'(obs.mis), 32'(mon_e.mis));
    end
  end

  function automatic exp_t outs(input logic [31:0] rdata, input logic [31:0] alu,
                                input logic [4:0] rd, input logic m2r, input logic rw,
                                input logic mis);
    exp_t e;
    e.stall = 1'b0; e.rdata = rdata; e.alu = alu; e.rd = rd;
    e.m2r = m2r; e.rw = rw; e.mis = mis;
    return e;
  endfunction

  // Push this cycle's expectation, then advance one edge.
  task automatic step(input logic exp_stall, input exp_t next_out);
    exp_t e;
    e = cur;
    e.stall = exp_stall;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cur = next_out;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic m2r, input logic rw);
    mem_read_in = rd_en; mem_write_in = wr_en; mem_addr_in = addr;
    write_data_in = wdata; rd_in = rd; mem_to_reg_in = m2r; reg_write_in = rw;
  endtask

  // exp_rdata is the hand-computed read_data_out for this op.
  task automatic op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [4:0] rd, input logic m2r,
                    input logic rw, input logic [31:0] exp_rdata);
    drive(rd_en, wr_en, addr, wdata, rd, m2r, rw);
    if (!(rd_en | wr_en)) begin
      step(1'b0, outs(32'h0, addr, rd, m2r, rw, 1'b0));
    end else if (addr[1:0] != 2'b00) begin
      step(1'b0, outs(32'h0, addr, 5'd0, 1'b0, 1'b0, 1'b1));
    end else begin
      for (int i = 0; i < lat; i++) step(1'b1, outs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      step(1'b0, outs(exp_rdata, addr, rd, m2r, rw, 1'b0));
    end
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset already asserted: all outputs and stall_out must read zero.
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cur = '0;
      exp_q.push_back('0);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cur = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    cur = '0;
    reset = 1'b1;
    // An aligned load sits on the inputs during reset; stall_out must stay low.
    drive(1'b1, 1'b0, 32'h40, 32'h0, 5'd1, 1'b1, 1'b1);
    hold_reset(2);

    // Reset mid-access: preload 0x10 with zero, then abort a store there.
    op(1'b0, 1'b1, 32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    step(1'b1, outs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    e = cur; e.stall = 1'b1; exp_q.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b1;
    hold_reset(2);
    op(1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 32'h00000000);

    // Store then load, same word back-to-back.
    op(1'b0, 1'b1, 32'h40, 32'h12345678, 5'd0, 1'b0, 1'b0, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1, 32'h12345678);

    // ALU passthrough.
    op(1'b0, 1'b0, 32'hABCD0000, 32'h0, 5'd7, 1'b0, 1'b1, 32'h0);

    // Misaligned load and store are dropped; 0x40 keeps its value.
    op(1'b1, 1'b0, 32'h42, 32'h0, 5'd9, 1'b1, 1'b1, 32'h0);
    op(1'b0, 1'b1, 32'h41, 32'h0BADBAD0, 5'd4, 1'b0, 1'b1, 32'h0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 1'b1, 1'b1, 32'h12345678);

    // Address wrap; the store's reg_write passes through.
    op(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 5'd4, 1'b0, 1'b1, 32'h0);
    op(1'b1, 1'b0, 32'h000, 32'h0, 5'd10, 1'b1, 1'b1, 32'hCAFEF00D);
    idle(); idle(); idle();

    // LATENCY=1 instance: read+write together behaves as a write.
    sel = 1;
    lat = 1;
    op(1'b1, 1'b1, 32'h80, 32'h5A5A5A5A, 5'd2, 1'b0, 1'b1, 32'h0);
    op(1'b1, 1'b0, 32'h80, 32'h0, 5'd8, 1'b1, 1'b1, 32'h5A5A5A5A);
    op(1'b0, 1'b1, 32'h84, 32'h0000BEEF, 5'd0, 1'b0, 1'b0, 32'h0);
    op(1'b1, 1'b0, 32'h84, 32'h0, 5'd31, 1'b1, 1'b1, 32'h0000BEEF);
    idle();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
